// File: rtl/beat_pkg.sv
// Shared types and constants for the beat recorder/player and its rate_divider neighbour.
package beat_pkg;

  localparam int unsigned CODE_W = 7;

  localparam logic [CODE_W-1:0] NO_KEY = 7'd0;

  // Note keys understood by rate_divider
  localparam logic [CODE_W-1:0] KEY_A = 7'd65;
  localparam logic [CODE_W-1:0] KEY_S = 7'd83;
  localparam logic [CODE_W-1:0] KEY_D = 7'd68;
  localparam logic [CODE_W-1:0] KEY_F = 7'd70;
  localparam logic [CODE_W-1:0] KEY_G = 7'd71;
  localparam logic [CODE_W-1:0] KEY_H = 7'd72;
  localparam logic [CODE_W-1:0] KEY_J = 7'd74;
  localparam logic [CODE_W-1:0] KEY_W = 7'd87;
  localparam logic [CODE_W-1:0] KEY_E = 7'd69;
  localparam logic [CODE_W-1:0] KEY_T = 7'd84;
  localparam logic [CODE_W-1:0] KEY_Y = 7'd89;
  localparam logic [CODE_W-1:0] KEY_U = 7'd85;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } state_t;

  // Event word is {code, dur}: code in the high CODE_W bits, duration below it
  function automatic int unsigned event_width(input int unsigned dur_w);
    return CODE_W + dur_w;
  endfunction

endpackage

// File: rtl/beat_event_ram.sv
// Event store: one write port, one synchronous read port, block-RAM friendly.
module beat_event_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 17
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/beat_sequencer.sv
// Records the live key stream as (code, duration) events and replays it on the
// same 7-bit interface that feeds rate_divider.
module beat_sequencer
  import beat_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned DUR_W    = 10
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [CODE_W-1:0]      ascii_in,
  input  logic                   rec_start,
  input  logic                   play_start,
  input  logic                   stop,
  output logic [CODE_W-1:0]      ascii_out,
  output logic                   recording,
  output logic                   playing,
  output logic                   full,
  output logic                   done,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned EV_W  = event_width(DUR_W);

  localparam logic [DUR_W-1:0] DUR_MAX  = '1;
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  state_t            state, state_n;
  logic [CODE_W-1:0] key_q;
  logic [DIV_W-1:0]  div, div_n;
  logic [CODE_W-1:0] open_code, code_n;
  logic [DUR_W-1:0]  dur, dur_n;
  logic [CNT_W-1:0]  count_n;
  logic [CNT_W-1:0]  ptr, ptr_n;
  logic              play_load, load_n;
  logic              full_n, done_n, rec_n, play_n;
  logic [CODE_W-1:0] ascii_n;

  logic              tick;
  logic              we;
  logic [EV_W-1:0]   wdata;
  logic [EV_W-1:0]   rd_data;
  logic [CODE_W-1:0] ev_code;
  logic [DUR_W-1:0]  ev_dur;

  assign tick    = (div == DIV_LAST);
  assign ev_code = rd_data[EV_W-1 -: CODE_W];
  assign ev_dur  = rd_data[DUR_W-1:0];

  beat_event_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EV_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (count[AW-1:0]),
    .wdata (wdata),
    .raddr (ptr[AW-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      key_q     <= NO_KEY;
      div       <= '0;
      open_code <= NO_KEY;
      dur       <= '0;
      count     <= '0;
      ptr       <= '0;
      play_load <= 1'b0;
      full      <= 1'b0;
      done      <= 1'b0;
      recording <= 1'b0;
      playing   <= 1'b0;
      ascii_out <= NO_KEY;
    end else begin
      state     <= state_n;
      key_q     <= ascii_in;
      div       <= div_n;
      open_code <= code_n;
      dur       <= dur_n;
      count     <= count_n;
      ptr       <= ptr_n;
      play_load <= load_n;
      full      <= full_n;
      done      <= done_n;
      recording <= rec_n;
      playing   <= play_n;
      ascii_out <= ascii_n;
    end
  end

  // In PLAY, dur holds the ticks left in the event on air and ptr the next event to fetch
  always_comb begin
    state_n = state;
    div_n   = div;
    code_n  = open_code;
    dur_n   = dur;
    count_n = count;
    ptr_n   = ptr;
    load_n  = 1'b0;
    full_n  = full;
    done_n  = 1'b0;
    ascii_n = key_q;
    we      = 1'b0;
    wdata   = {open_code, dur};

    case (state)
      IDLE: begin
        div_n = '0;
        ptr_n = '0;
        if (!stop) begin
          if (rec_start) begin
            state_n = REC;
            count_n = '0;
            full_n  = 1'b0;
            code_n  = key_q;
            dur_n   = '0;
          end else if (play_start) begin
            if (count == '0) begin
              done_n = 1'b1;
            end else begin
              state_n = PLAY;
              load_n  = 1'b1;
              ascii_n = NO_KEY;
            end
          end
        end
      end

      REC: begin
        div_n = tick ? '0 : div + DIV_W'(1);
        if (stop) begin
          we      = (dur != '0);
          state_n = IDLE;
        end else if (key_q != open_code) begin
          // Events shorter than one tick are glitches and are dropped
          we     = (dur != '0);
          code_n = key_q;
          dur_n  = '0;
        end else if (dur == DUR_MAX) begin
          we    = 1'b1;
          dur_n = '0;
        end else if (tick) begin
          dur_n = dur + DUR_W'(1);
        end
        if (we) begin
          count_n = count + CNT_W'(1);
          if (count_n == CNT_FULL) begin
            full_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end

      PLAY: begin
        ascii_n = ascii_out;
        div_n   = tick ? '0 : div + DIV_W'(1);
        if (stop) begin
          state_n = IDLE;
          ascii_n = NO_KEY;
        end else if (play_load) begin
          ascii_n = ev_code;
          dur_n   = ev_dur;
          ptr_n   = ptr + CNT_W'(1);
          div_n   = '0;
        end else if (tick && dur == DUR_ONE) begin
          if (ptr == count) begin
            ascii_n = NO_KEY;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            // rd_data already holds the prefetched next event, so no gap cycle
            ascii_n = ev_code;
            dur_n   = ev_dur;
            ptr_n   = ptr + CNT_W'(1);
          end
        end else if (tick) begin
          dur_n = dur - DUR_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    rec_n  = (state_n == REC);
    play_n = (state_n == PLAY);
  end

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer: replay output is scoreboarded per cycle,
// status outputs are checked directly at hand-computed cycles.
module tb_beat_sequencer;
  import beat_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DUR_W    = 3;
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;

  logic              clk;
  logic              resetn;
  logic [CODE_W-1:0] ascii_in;
  logic              rec_start;
  logic              play_start;
  logic              stop;
  logic [CODE_W-1:0] ascii_out;
  logic              recording;
  logic              playing;
  logic              full;
  logic              done;
  logic [CNT_W-1:0]  count;

  int vectors     = 0;
  int miscompares = 0;

  // Each entry is {done, ascii_out} for one cycle where playing or done is high
  logic [7:0] exp_q[$];

  beat_sequencer #(
    .DEPTH    (DEPTH),
    .TICK_DIV (TICK_DIV),
    .DUR_W    (DUR_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ascii_in   (ascii_in),
    .rec_start  (rec_start),
    .play_start (play_start),
    .stop       (stop),
    .ascii_out  (ascii_out),
    .recording  (recording),
    .playing    (playing),
    .full       (full),
    .done       (done),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [CODE_W-1:0] code, input int n);
    ascii_in = code;
    cyc(n);
  endtask

  task automatic pulse_rec();
    rec_start = 1'b1;
    cyc(1);
    rec_start = 1'b0;
  endtask

  task automatic pulse_play();
    play_start = 1'b1;
    cyc(1);
    play_start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic expect_run(input logic [CODE_W-1:0] code, input int n);
    repeat (n) exp_q.push_back({1'b0, code});
  endtask

  task automatic expect_done();
    exp_q.push_back({1'b1, NO_KEY});
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      cyc(1);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: pops one expectation per cycle in which the DUT presents replay output
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (resetn && (playing || done)) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_out: got done=%0d ascii_out=%0d, required no replay output",
                   done, ascii_out);
        end else begin
          e = exp_q.pop_front();
          if ({done, ascii_out} !== e) begin
            miscompares++;
            $display("FAIL replay: got done=%0d ascii_out=%0d, required done=%0d ascii_out=%0d",
                     done, ascii_out, e[7], e[6:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    resetn     = 1'b0;
    ascii_in   = NO_KEY;
    rec_start  = 1'b0;
    play_start = 1'b0;
    stop       = 1'b0;
    cyc(2);
    check("rst_ascii_out", int'(ascii_out), 0);
    check("rst_recording", int'(recording), 0);
    check("rst_playing",   int'(playing), 0);
    check("rst_full",      int'(full), 0);
    check("rst_done",      int'(done), 0);
    check("rst_count",     int'(count), 0);
    resetn = 1'b1;
    cyc(1);

    // Live passthrough: two-cycle latency
    ascii_in = KEY_T;
    cyc(1);
    check("pass_lat1", int'(ascii_out), 0);
    cyc(1);
    check("pass_lat2", int'(ascii_out), int'(KEY_T));
    hold(NO_KEY, 2);

    // Empty playback
    expect_done();
    pulse_play();
    check("empty_playing", int'(playing), 0);
    check("empty_done", int'(done), 1);
    cyc(1);
    check("empty_done_pulse", int'(done), 0);
    check("empty_drain", exp_q.size(), 0);

    // Basic record: A 3 ticks, silence 2 ticks, S 4 ticks
    ascii_in = KEY_A;
    cyc(1);
    pulse_rec();
    check("basic_recording", int'(recording), 1);
    hold(KEY_A, 11);
    hold(NO_KEY, 8);
    hold(KEY_S, 17);
    pulse_stop();
    check("basic_count", int'(count), 3);
    check("basic_rec_off", int'(recording), 0);
    hold(NO_KEY, 2);

    expect_run(NO_KEY, 1);
    expect_run(KEY_A, 12);
    expect_run(NO_KEY, 8);
    expect_run(KEY_S, 16);
    expect_done();
    pulse_play();
    check("basic_playing", int'(playing), 1);
    wait_drain("basic_drain", 100);
    check("basic_play_off", int'(playing), 0);

    // Abort replay after five cycles of A
    cyc(2);
    expect_run(NO_KEY, 1);
    expect_run(KEY_A, 5);
    pulse_play();
    cyc(5);
    pulse_stop();
    check("abort_ascii", int'(ascii_out), 0);
    check("abort_playing", int'(playing), 0);
    check("abort_done", int'(done), 0);
    cyc(1);
    check("abort_done_late", int'(done), 0);
    check("abort_count", int'(count), 3);
    check("abort_drain", exp_q.size(), 0);

    // Glitch: W for 2 clocks between two E presses is dropped
    ascii_in = KEY_E;
    cyc(1);
    pulse_rec();
    hold(KEY_E, 7);
    hold(KEY_W, 2);
    hold(KEY_E, 11);
    pulse_stop();
    check("glitch_count", int'(count), 2);
    hold(NO_KEY, 2);
    expect_run(NO_KEY, 1);
    expect_run(KEY_E, 20);
    expect_done();
    pulse_play();
    wait_drain("glitch_drain", 100);

    // Full buffer: five keys, one tick each, only four fit
    ascii_in = KEY_F;
    cyc(1);
    pulse_rec();
    hold(KEY_F, 3);
    hold(KEY_G, 4);
    hold(KEY_H, 4);
    hold(KEY_J, 4);
    hold(KEY_W, 4);
    check("full_flag", int'(full), 1);
    check("full_count", int'(count), 4);
    check("full_rec_off", int'(recording), 0);
    hold(NO_KEY, 2);
    expect_run(NO_KEY, 1);
    expect_run(KEY_F, 4);
    expect_run(KEY_G, 4);
    expect_run(KEY_H, 4);
    expect_run(KEY_J, 4);
    expect_done();
    pulse_play();
    wait_drain("full_drain", 100);

    // Saturation: D for 10 ticks splits into 7 + 3
    ascii_in = KEY_D;
    cyc(1);
    pulse_rec();
    check("sat_full_cleared", int'(full), 0);
    hold(KEY_D, 40);
    pulse_stop();
    check("sat_count", int'(count), 2);
    hold(NO_KEY, 2);
    expect_run(NO_KEY, 1);
    expect_run(KEY_D, 40);
    expect_done();
    pulse_play();
    wait_drain("sat_drain", 100);

    // Simultaneous starts pick REC; then async reset mid-recording
    ascii_in = KEY_U;
    cyc(1);
    rec_start  = 1'b1;
    play_start = 1'b1;
    cyc(1);
    rec_start  = 1'b0;
    play_start = 1'b0;
    check("both_recording", int'(recording), 1);
    check("both_playing", int'(playing), 0);
    hold(KEY_U, 4);
    hold(KEY_Y, 2);
    check("mid_count", int'(count), 1);
    check("mid_ascii", int'(ascii_out), int'(KEY_Y));
    #2;
    resetn = 1'b0;
    #1;
    check("arst_ascii_out", int'(ascii_out), 0);
    check("arst_recording", int'(recording), 0);
    check("arst_playing",   int'(playing), 0);
    check("arst_full",      int'(full), 0);
    check("arst_done",      int'(done), 0);
    check("arst_count",     int'(count), 0);
    ascii_in = NO_KEY;
    cyc(2);
    resetn = 1'b1;
    cyc(2);
    check("post_rst_recording", int'(recording), 0);
    check("post_rst_count", int'(count), 0);
    check("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Records the live key stream feeding `rate_divider` as (key code, duration) events and replays it later on the same 7-bit ASCII interface, so `rate_divider` cannot tell live from recorded play. It sits between the keyboard/ASCII source and `rate_divider`. Its `ascii_out` drives `rate_divider.ascii`, and durations are counted in coarse ticks derived from the 50 MHz clock.

## Interface
- `DEPTH`, 64: number of event slots; `count` width is clog2(DEPTH)+1.
- `TICK_DIV`, 500000: clocks per duration tick (10 ms at 50 MHz); ≥2.
- `DUR_W`, 10: duration field width in ticks; max event length is 2^DUR_W−1 ticks.
- `clk` in 1: system clock, 50 MHz.
- `resetn` in 1: asynchronous, active-low reset.
- `ascii_in` in 7: live key code; 0 means no key.
- `rec_start` in 1: one-cycle pulse; clears memory and starts recording.
- `play_start` in 1: one-cycle pulse; starts replay of stored events.
- `stop` in 1: one-cycle pulse; ends recording or aborts replay.
- `ascii_out` out 7: code to `rate_divider`.
- `recording` out 1: high in REC state.
- `playing` out 1: high in PLAY state.
- `full` out 1: sticky; set when recording hit DEPTH; cleared by next `rec_start`.
- `done` out 1: one-cycle pulse when replay finishes naturally, not via `stop`.
- `count` out clog2(DEPTH)+1: number of stored events.

## Operation
- **Input sync:** `ascii_in` is registered once (`key_q`). All decisions use `key_q`.
- **States:** IDLE, REC, PLAY.
- **Command priority:** `stop` > `rec_start` > `play_start`.
  - Starts are ignored outside IDLE.
  - `stop` in IDLE is a no-op.
- **IDLE:** `ascii_out` = `key_q` (live passthrough).
- **IDLE → REC on `rec_start`:**
  - Clear `count` and `full`.
  - Open event: code = `key_q`, dur = 0.
  - Tick divider restarts at 0.
- **REC:**
  - `ascii_out` = `key_q`, so the player hears themselves.
  - Each tick (divider wraps at TICK_DIV−1) increments dur.
  - When `key_q` ≠ open code:
    - If dur > 0, write the event and increment `count`.
    - If dur == 0, discard it (glitch shorter than one tick).
    - Either way, open a new event with code = `key_q`, dur = 0. The divider is not reset.
  - When dur reaches 2^DUR_W−1: write the event and open a new one with the same code.
  - Silence (code 0) is recorded as an ordinary event.
  - When `count` reaches DEPTH after a write: set `full`, go to IDLE.
  - On `stop`: flush the open event if dur > 0 and not full, then go to IDLE.
- **IDLE → PLAY on `play_start`:**
  - If `count` == 0: pulse `done` next cycle and stay in IDLE.
- **PLAY:**
  - Events 0..count−1 are emitted in order.
  - Event k drives `ascii_out` = code_k for exactly dur_k×TICK_DIV clocks.
  - Next event code follows on the following cycle with no gap; this needs a prefetch.
  - After the last event: `ascii_out` = 0 for one cycle and `done` = 1 in that cycle, then IDLE.
  - On `stop`: `ascii_out` = 0 next cycle, then IDLE, no `done`. Memory and `count` are preserved.
- **Arithmetic:** dur saturates and never wraps. The address counter wraps only via the DEPTH check.

## Timing
- **Reset values:** state IDLE; `ascii_out` 0, `recording` 0, `playing` 0, `full` 0, `done` 0, `count` 0; divider 0. Memory contents are undefined, but unreachable because `count` = 0.
- **Reset mid-operation:** immediately forces reset values. No partial event is written.
- **Live passthrough latency:** `ascii_in` → `ascii_out` is 2 cycles (sync register + output register).
- **`rec_start` at cycle T:**
  - `recording` = 1 at T+1.
  - First tick at T+1+TICK_DIV.
- **`play_start` at cycle T:**
  - `playing` = 1 at T+1.
  - `ascii_out` = code_0 at T+2.
- **Event write:** occurs the cycle after the change is detected on `key_q`. `count` updates the same cycle as the write.
- **`stop` at cycle T:** `recording`/`playing` = 0 at T+1.
- **Memory:** synchronous write and synchronous read, one-cycle read latency. This latency is hidden by the prefetch in PLAY.

## Structure
- Package `beat_pkg`:
  - State enum (IDLE/REC/PLAY).
  - NO_KEY = 7'd0.
  - Event record layout: code[6:0] in the high field, dur in the low field; total width 7+DUR_W.
  - Note ASCII constants A, S, D, F, G, H, J, W, E, T, Y, U, shared with `rate_divider`.
- Sub-module `beat_event_ram`:
  - DEPTH × (7+DUR_W).
  - One write port, one read port, synchronous read.
  - Inferable as block RAM.
- The FSM, tick divider and counters live in `beat_sequencer`.

## Test plan
- **Basic record and replay** (TICK_DIV=4):
  - Stimulus: `rec_start`; hold 'A'(65) for 12 clocks, 0 for 8 clocks, 'S'(83) for 16 clocks; then `stop`.
  - Required: `count` = 3, stored (65,3), (0,2), (83,4).
  - Then `play_start`. Required: `ascii_out` = 65 for 12 clocks, 0 for 8, 83 for 16, then `done` pulse and `playing` falls.
- **Glitch rejection:**
  - Stimulus: 'W'(87) held for 2 clocks (< TICK_DIV) between two 'E'(69) presses.
  - Required: no 87 event; one 69 event per press.
- **Full buffer:**
  - Stimulus: DEPTH=4, five distinct keys, each held 1 tick.
  - Required: `full` = 1, `count` = 4, `recording` = 0, fifth key absent on replay.
- **Saturation:**
  - Stimulus: DUR_W=3; hold 'D'(68) for 10 ticks.
  - Required: events (68,7) and (68,3).
- **Abort and empty playback:**
  - Stimulus: `stop` mid-PLAY.
  - Required: `ascii_out` = 0 next cycle, no `done`, `count` unchanged.
  - Stimulus: `play_start` with `count` = 0.
  - Required: `done` pulses, `playing` stays 0.
- **Simultaneous commands and async reset:**
  - Stimulus: `rec_start` and `play_start` together in IDLE. Required: REC entered.
  - Stimulus: `resetn` low mid-REC. Required: all outputs return to reset values with no clock edge.
